// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Drives the select of a 4:1 channel mux through the Gray order
// 00 -> 01 -> 11 -> 10 and holds each code for (dwell+1) cycles. The mux
// output is sampled at the end of each channel's dwell. A completed sweep
// is published as a 4-bit snapshot with a one-cycle valid pulse. Scanning
// can be one-shot or continuous. All outputs are registered.
module mux_scan_sequencer #(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic [DW-1:0]    dwell,
    input  logic             mux_z,
    output logic [1:0]       sel,
    output logic [3:0]       sample_vec,
    output logic             sweep_valid,
    output logic             busy,
    output logic [CNT_W-1:0] sweep_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // Channel index to mux select code (Gray order).
    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        logic [1:0] code;
        case (idx)
            2'd0:    code = 2'b00;
            2'd1:    code = 2'b01;
            2'd2:    code = 2'b11;
            2'd3:    code = 2'b10;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    logic [0:0]       r_state;
    logic [1:0]       r_sel;
    logic [1:0]       r_idx;
    logic [DW-1:0]    r_dcnt;
    logic [2:0]       r_shadow;
    logic [3:0]       r_sample_vec;
    logic             r_sweep_valid;
    logic             r_busy;
    logic [CNT_W-1:0] r_sweep_cnt;

    logic [0:0]       w_state_nxt;
    logic [1:0]       w_sel_nxt;
    logic [1:0]       w_idx_nxt;
    logic [DW-1:0]    w_dcnt_nxt;
    logic [2:0]       w_shadow_nxt;
    logic [3:0]       w_sample_vec_nxt;
    logic             w_sweep_valid_nxt;
    logic [CNT_W-1:0] w_sweep_cnt_nxt;

    // Next-state logic: sweep sequencing, dwell counting and sample capture.
    always_comb begin
        w_state_nxt       = r_state;
        w_sel_nxt         = r_sel;
        w_idx_nxt         = r_idx;
        w_dcnt_nxt        = r_dcnt;
        w_shadow_nxt      = r_shadow;
        w_sample_vec_nxt  = r_sample_vec;
        w_sweep_valid_nxt = 1'b0;
        w_sweep_cnt_nxt   = r_sweep_cnt;
        case (r_state)
            ST_IDLE: begin
                w_sel_nxt = 2'b00;
                // stop has priority, so start+stop leaves the sequencer idle
                if (start && !stop) begin
                    w_state_nxt = ST_SCAN;
                    w_idx_nxt   = 2'd0;
                    w_dcnt_nxt  = dwell;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    // abort: partial samples are simply never published
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = 2'b00;
                    w_idx_nxt   = 2'd0;
                end else if (r_dcnt != {DW{1'b0}}) begin
                    w_dcnt_nxt = r_dcnt - DW'(1);
                end else if (r_idx == 2'd3) begin
                    // last channel goes straight into the published vector
                    w_sample_vec_nxt  = {mux_z, r_shadow};
                    w_sweep_valid_nxt = 1'b1;
                    w_sweep_cnt_nxt   = r_sweep_cnt + CNT_W'(1);
                    w_idx_nxt         = 2'd0;
                    w_sel_nxt         = 2'b00;
                    w_dcnt_nxt        = dwell;
                    if (cont) begin
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    case (r_idx)
                        2'd0:    w_shadow_nxt[0] = mux_z;
                        2'd1:    w_shadow_nxt[1] = mux_z;
                        2'd2:    w_shadow_nxt[2] = mux_z;
                        default: w_shadow_nxt    = r_shadow;
                    endcase
                    w_idx_nxt  = r_idx + 2'd1;
                    w_sel_nxt  = idx_to_sel(r_idx + 2'd1);
                    w_dcnt_nxt = dwell;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = 2'b00;
                w_idx_nxt   = 2'd0;
                w_dcnt_nxt  = {DW{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_sel         <= 2'b00;
            r_idx         <= 2'd0;
            r_dcnt        <= {DW{1'b0}};
            r_shadow      <= 3'b000;
            r_sample_vec  <= 4'b0000;
            r_sweep_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_sweep_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_idx         <= w_idx_nxt;
            r_dcnt        <= w_dcnt_nxt;
            r_shadow      <= w_shadow_nxt;
            r_sample_vec  <= w_sample_vec_nxt;
            r_sweep_valid <= w_sweep_valid_nxt;
            r_busy        <= (w_state_nxt == ST_SCAN);
            r_sweep_cnt   <= w_sweep_cnt_nxt;
        end
    end

    assign sel         = r_sel;
    assign sample_vec  = r_sample_vec;
    assign sweep_valid = r_sweep_valid;
    assign busy        = r_busy;
    assign sweep_cnt   = r_sweep_cnt;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a behavioural channel/hold-time model is
// compared against every output after each rising edge.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [3:0] sig = 4'd0;
    logic       mux_z;
    logic [1:0] sel;
    logic [3:0] sample_vec;
    logic       sweep_valid;
    logic       busy;
    logic [7:0] sweep_cnt;

    int gray [4] = '{0, 1, 3, 2};

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = 0;

    // behavioural model
    bit       m_busy;
    int       m_ch, m_hold, m_el, m_cnt;
    bit [3:0] m_bits, m_vec;
    bit       m_valid;

    always #5 clk = ~clk;

    // 4:1 mux being scanned: channel index is the position of sel in the Gray order
    always_comb begin
        mux_z = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (int'(sel) == gray[i]) mux_z = sig[i];
        end
    end

    mux_scan_sequencer #(.DW(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
        .dwell(dwell), .mux_z(mux_z), .sel(sel), .sample_vec(sample_vec),
        .sweep_valid(sweep_valid), .busy(busy), .sweep_cnt(sweep_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ch = 0; m_hold = 0; m_el = 0; m_cnt = 0;
        m_bits = 4'd0; m_vec = 4'd0; m_valid = 0;
    endtask

    // One rising edge of the specified behaviour: each channel is held for
    // (dwell sampled at channel entry)+1 cycles, then its mux value is taken.
    task automatic model_step();
        m_valid = 0;
        if (!m_busy) begin
            if (start && !stop) begin
                m_busy = 1; m_ch = 0; m_el = 0; m_hold = int'(dwell) + 1;
            end
        end else if (stop) begin
            m_busy = 0; m_ch = 0;
        end else begin
            m_el++;
            if (m_el == m_hold) begin
                m_bits[m_ch] = sig[m_ch];
                m_el = 0;
                m_hold = int'(dwell) + 1;
                if (m_ch == 3) begin
                    m_vec = m_bits;
                    m_valid = 1;
                    m_cnt = (m_cnt + 1) % 256;
                    m_ch = 0;
                    m_busy = cont;
                end else begin
                    m_ch++;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("sel", int'(sel), m_busy ? gray[m_ch] : 0);
        chk("sample_vec", int'(sample_vec), int'(m_vec));
        chk("sweep_valid", int'(sweep_valid), int'(m_valid));
        chk("busy", int'(busy), int'(m_busy));
        chk("sweep_cnt", int'(sweep_cnt), m_cnt);
        if (sweep_valid) begin
            pulses++;
            last_pulse = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        cyc++;
        #1;
        compare_all();
    endtask

    initial begin
        int c0, p0, prev, spacing_bad, done;
        bit [3:0] s_vec;
        int s_cnt;
        model_reset();
        tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_sel", int'(sel), 0);
        rst_n = 1'b1;
        tick();

        // T2 one-shot, dwell 0
        dwell = 8'd0; cont = 1'b0; sig = 4'b1010; start = 1'b1;
        tick(); c0 = cyc; p0 = pulses; start = 1'b0;
        repeat (6) tick();
        chk("t2_vec", int'(sample_vec), 4'b1010);
        chk("t2_cnt", int'(sweep_cnt), 1);
        chk("t2_pulses", pulses - p0, 1);
        chk("t2_latency", last_pulse - c0, 4);
        chk("t2_idle", int'(busy), 0);

        // T3 dwell 3
        dwell = 8'd3; sig = 4'b0110; start = 1'b1;
        tick(); c0 = cyc; start = 1'b0;
        repeat (18) tick();
        chk("t3_vec", int'(sample_vec), 4'b0110);
        chk("t3_latency", last_pulse - c0, 16);
        chk("t3_cnt", int'(sweep_cnt), 2);

        // T1 asynchronous reset mid-sweep
        start = 1'b1; sig = 4'b1111;
        tick(); start = 1'b0;
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t1_sel", int'(sel), 0);
        chk("t1_vec", int'(sample_vec), 0);
        chk("t1_valid", int'(sweep_valid), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_cnt", int'(sweep_cnt), 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t1_recover", int'(busy), 0);

        // T4 continuous, dwell 1, alternating F/0, counter wrap
        dwell = 8'd1; cont = 1'b1; sig = 4'hF; start = 1'b1;
        tick(); c0 = cyc; p0 = pulses; prev = c0; start = 1'b0;
        spacing_bad = 0; done = 0;
        for (int i = 0; i < 256 * 8 + 40; i++) begin
            tick();
            if (sweep_valid) begin
                if (last_pulse - prev != 8) spacing_bad++;
                prev = last_pulse;
                chk("t4_alt", int'(sample_vec), ((pulses - p0) % 2 == 1) ? 15 : 0);
                if (pulses - p0 == 255) chk("t4_cnt255", int'(sweep_cnt), 255);
                sig = ~sig;
                if (pulses - p0 == 256) begin
                    done = 1;
                    break;
                end
            end
        end
        chk("t4_done", done, 1);
        chk("t4_spacing", spacing_bad, 0);
        chk("t4_wrap", int'(sweep_cnt), 0);
        cont = 1'b0;
        done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!busy) begin
                done = 1;
                break;
            end
        end
        chk("t4_drain", done, 1);

        // T5 abort during channel 2 dwell
        dwell = 8'd2; sig = 4'b0101; start = 1'b1;
        tick(); start = 1'b0;
        s_vec = m_vec; s_cnt = m_cnt; p0 = pulses; done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_busy && m_ch == 2 && m_el == 1) begin
                done = 1;
                break;
            end
        end
        chk("t5_reach", done, 1);
        stop = 1'b1;
        tick(); stop = 1'b0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_sel", int'(sel), 0);
        chk("t5_vec", int'(sample_vec), int'(s_vec));
        chk("t5_cnt", int'(sweep_cnt), s_cnt);
        repeat (3) tick();
        chk("t5_nopulse", pulses - p0, 0);
        start = 1'b1; stop = 1'b1;
        repeat (2) tick();
        chk("t5_startstop", int'(busy), 0);
        start = 1'b0; stop = 1'b0;

        // T6 start while busy, dwell changed mid-dwell
        dwell = 8'd5; sig = 4'b1001; start = 1'b1;
        tick(); c0 = cyc; p0 = pulses; start = 1'b0;
        repeat (2) tick();
        start = 1'b1; dwell = 8'd1;
        repeat (3) tick();
        start = 1'b0;
        repeat (12) tick();
        chk("t6_latency", last_pulse - c0, 12);
        chk("t6_pulses", pulses - p0, 1);
        chk("t6_vec", int'(sample_vec), 4'b1001);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            cont  = ($urandom_range(0, 1) == 1);
            dwell = 8'($urandom_range(0, 3));
            sig   = 4'($urandom_range(0, 15));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
